// File: rtl/pc_redirect_unit_pkg.sv
// Shared PC-stage definitions: state encodings, datapath width, increment.
// Imported by the PC stage, the hazard unit and the testbench.
package pc_redirect_unit_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = XLEN;

    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        PCS_RUN   = 2'd0,
        PCS_FLUSH = 2'd1,
        PCS_HALT  = 2'd2,
        PCS_TRAP  = 2'd3
    } pcState_t;

    // JALR rule: the low target bit never reaches the PC.
    function automatic logic [PC_W-1:0] alignTarget(
        input logic [PC_W-1:0] a
    );
        return a & ~PC_W'(1);
    endfunction

endpackage

// File: rtl/pc_redirect_unit_flush_sequencer.sv
// Flush sequencer: 3-bit down-counter plus registered flush flag.
// Ports: load (restart count), hold (force flush on), step (non-stalled cycle);
// flush (registered), done (counter at zero).
module flush_sequencer #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic hold,
    input  logic step,
    output logic flush,
    output logic done
);

    localparam logic [2:0] RELOAD = 3'(DEPTH - 1);

    logic [2:0] cnt;
    logic       flushQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            flushQ <= 1'b0;
        end else if (load) begin
            cnt    <= RELOAD;
            flushQ <= 1'b1;
        end else if (hold) begin
            flushQ <= 1'b1;
        end else if (flushQ && step) begin
            if (cnt == 3'd0) begin
                flushQ <= 1'b0;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    assign flush = flushQ;
    assign done  = (cnt == 3'd0);

endmodule

// File: rtl/pc_redirect_unit.sv
// PC stage: fetch PC register, next-PC mux, redirect/flush/halt FSM, link adder.
// Ports: clk, rst, stall, should_jump, target, halt_req in; pc, pc_plus4,
// fetch_valid, flush, halted, misaligned out.
// Option macro PC_MISALIGN_TRAP_EN: target[1]=1 redirects to TRAP_VEC.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FLUSH_DEPTH = 2,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            should_jump,
    input  logic [PC_W-1:0] target,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            flush,
    output logic            halted,
    output logic            misaligned
);

    pcState_t        state;
    pcState_t        stateNext;
    logic [PC_W-1:0] pcNext;
    logic [PC_W-1:0] jumpPc;
    pcState_t        jumpState;
    logic            redirect;
    logic            seqDone;

    assign pc_plus4 = pc + PC_INC;

    // Halted core ignores everything; halt_req outranks a redirect.
    assign redirect = should_jump && !halt_req
                      && (state != PCS_HALT);

`ifdef PC_MISALIGN_TRAP_EN
    assign jumpPc    = target[1] ? TRAP_VEC : alignTarget(target);
    assign jumpState = target[1] ? PCS_TRAP : PCS_FLUSH;

    logic misQ;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misQ <= 1'b0;
        end else if (redirect && target[1]) begin
            misQ <= 1'b1;
        end
    end
    assign misaligned = misQ;
`else
    assign jumpPc     = alignTarget(target);
    assign jumpState  = PCS_FLUSH;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PCS_RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            PCS_HALT: stateNext = PCS_HALT;
            PCS_RUN: begin
                if (halt_req) begin
                    stateNext = PCS_HALT;
                end else if (should_jump) begin
                    stateNext = jumpState;
                end
            end
            default: begin
                if (halt_req) begin
                    stateNext = PCS_HALT;
                end else if (should_jump) begin
                    stateNext = jumpState;
                end else if (!stall && seqDone) begin
                    stateNext = PCS_RUN;
                end
            end
        endcase
    end

    always_comb begin
        fetch_valid = (state == PCS_RUN) && !stall && !flush;
        halted      = (state == PCS_HALT);
    end

    // Redirect beats stall; during a flush the new stream keeps fetching.
    always_comb begin
        pcNext = pc;
        if (state != PCS_HALT && !halt_req) begin
            if (should_jump) begin
                pcNext = jumpPc;
            end else if (!stall) begin
                pcNext = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pcNext;
        end
    end

    flush_sequencer #(
        .DEPTH(FLUSH_DEPTH)
    ) uSeq (
        .clk  (clk),
        .rst  (rst),
        .load (redirect),
        .hold (stateNext == PCS_HALT),
        .step (!stall),
        .flush(flush),
        .done (seqDone)
    );

endmodule
